// File: rtl/argmax_pkg.sv
// Shared types, defaults and sizing helper for the sequential top-2 argmax block.
package argmax_pkg;

  localparam int DEF_DATA_WIDTH  = 30;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_LANES       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so every index field has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_top2_cmp.sv
// Folds one candidate score into a running best/second pair (combinational).
module argmax_top2_cmp #(
  parameter int DW = 30,
  parameter int IW = 4
) (
  input  logic                 cand_en,
  input  logic signed [DW-1:0] cand_sc,
  input  logic        [IW-1:0] cand_idx,
  input  logic                 best_vld_i,
  input  logic signed [DW-1:0] best_sc_i,
  input  logic        [IW-1:0] best_idx_i,
  input  logic                 sec_vld_i,
  input  logic signed [DW-1:0] sec_sc_i,
  input  logic        [IW-1:0] sec_idx_i,
  output logic                 best_vld_o,
  output logic signed [DW-1:0] best_sc_o,
  output logic        [IW-1:0] best_idx_o,
  output logic                 sec_vld_o,
  output logic signed [DW-1:0] sec_sc_o,
  output logic        [IW-1:0] sec_idx_o
);

  // Valid flags let the first real candidates fill empty slots even when they
  // equal the most-negative seed value; strict compares keep ties on the lower index.
  always_comb begin
    best_vld_o = best_vld_i;
    best_sc_o  = best_sc_i;
    best_idx_o = best_idx_i;
    sec_vld_o  = sec_vld_i;
    sec_sc_o   = sec_sc_i;
    sec_idx_o  = sec_idx_i;
    if (cand_en) begin
      if (!best_vld_i || (cand_sc > best_sc_i)) begin
        best_vld_o = 1'b1;
        best_sc_o  = cand_sc;
        best_idx_o = cand_idx;
        sec_vld_o  = best_vld_i;
        sec_sc_o   = best_sc_i;
        sec_idx_o  = best_idx_i;
      end else if (!sec_vld_i || (cand_sc > sec_sc_i)) begin
        sec_vld_o = 1'b1;
        sec_sc_o  = cand_sc;
        sec_idx_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/argmax_seq_top2.sv
// Sequential top-2 argmax: captures a score vector, scans LANES classes per cycle,
// then holds predict/runner_up/max_score/margin with ready until out_ack.
module argmax_seq_top2
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int LANES       = DEF_LANES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] layer_out,
  input  logic                              valid,
  output logic                              in_ready,
  output logic                              ready,
  input  logic                              out_ack,
  output logic [31:0]                       predict,
  output logic [31:0]                       runner_up,
  output logic [DATA_WIDTH-1:0]             max_score,
  output logic [DATA_WIDTH:0]               margin
);

  localparam int IW     = clog2(NUM_CLASSES);
  localparam int NCHUNK = (NUM_CLASSES + LANES - 1) / LANES;
  localparam int DEPTH  = NCHUNK * LANES;
  localparam int PIW    = clog2(DEPTH);
  localparam int CW     = clog2(NCHUNK + 1);
  localparam logic [DATA_WIDTH-1:0] MIN_SC = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                           state_q, state_d;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] vec_q, vec_d;
  logic [CW-1:0]                    chunk_q, chunk_d;
  logic                             best_vld_q, best_vld_d, sec_vld_q, sec_vld_d;
  logic signed [DATA_WIDTH-1:0]     best_sc_q, best_sc_d, sec_sc_q, sec_sc_d;
  logic [IW-1:0]                    best_idx_q, best_idx_d, sec_idx_q, sec_idx_d;
  logic [IW-1:0]                    pred_q, pred_d, run_q, run_d;
  logic [DATA_WIDTH-1:0]            max_q, max_d;
  logic [DATA_WIDTH:0]              margin_q, margin_d;
  logic                             in_ready_q, in_ready_d, ready_q, ready_d;

  // Scores padded out to a whole number of chunks; padding lanes are masked off.
  logic signed [DATA_WIDTH-1:0] sc_pad [DEPTH];

  always_comb begin
    sc_pad = '{default: '0};
    for (int k = 0; k < NUM_CLASSES; k++) begin
      sc_pad[k] = vec_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  logic                         ch_best_vld [LANES+1];
  logic signed [DATA_WIDTH-1:0] ch_best_sc  [LANES+1];
  logic [IW-1:0]                ch_best_idx [LANES+1];
  logic                         ch_sec_vld  [LANES+1];
  logic signed [DATA_WIDTH-1:0] ch_sec_sc   [LANES+1];
  logic [IW-1:0]                ch_sec_idx  [LANES+1];

  assign ch_best_vld[0] = best_vld_q;
  assign ch_best_sc[0]  = best_sc_q;
  assign ch_best_idx[0] = best_idx_q;
  assign ch_sec_vld[0]  = sec_vld_q;
  assign ch_sec_sc[0]   = sec_sc_q;
  assign ch_sec_idx[0]  = sec_idx_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PIW-1:0] lane_idx;
    logic           lane_en;
    assign lane_idx = PIW'(int'(chunk_q) * LANES + l);
    assign lane_en  = (int'(lane_idx) < NUM_CLASSES);

    argmax_top2_cmp #(
      .DW (DATA_WIDTH),
      .IW (IW)
    ) u_cmp (
      .cand_en    (lane_en),
      .cand_sc    (sc_pad[lane_idx]),
      .cand_idx   (IW'(lane_idx)),
      .best_vld_i (ch_best_vld[l]),
      .best_sc_i  (ch_best_sc[l]),
      .best_idx_i (ch_best_idx[l]),
      .sec_vld_i  (ch_sec_vld[l]),
      .sec_sc_i   (ch_sec_sc[l]),
      .sec_idx_i  (ch_sec_idx[l]),
      .best_vld_o (ch_best_vld[l+1]),
      .best_sc_o  (ch_best_sc[l+1]),
      .best_idx_o (ch_best_idx[l+1]),
      .sec_vld_o  (ch_sec_vld[l+1]),
      .sec_sc_o   (ch_sec_sc[l+1]),
      .sec_idx_o  (ch_sec_idx[l+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    chunk_d    = chunk_q;
    best_vld_d = best_vld_q;
    best_sc_d  = best_sc_q;
    best_idx_d = best_idx_q;
    sec_vld_d  = sec_vld_q;
    sec_sc_d   = sec_sc_q;
    sec_idx_d  = sec_idx_q;
    pred_d     = pred_q;
    run_d      = run_q;
    max_d      = max_q;
    margin_d   = margin_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          vec_d      = layer_out;
          chunk_d    = '0;
          best_vld_d = 1'b0;
          best_sc_d  = MIN_SC;
          best_idx_d = '0;
          sec_vld_d  = 1'b0;
          sec_sc_d   = MIN_SC;
          sec_idx_d  = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_vld_d = ch_best_vld[LANES];
        best_sc_d  = ch_best_sc[LANES];
        best_idx_d = ch_best_idx[LANES];
        sec_vld_d  = ch_sec_vld[LANES];
        sec_sc_d   = ch_sec_sc[LANES];
        sec_idx_d  = ch_sec_idx[LANES];
        chunk_d    = chunk_q + 1'b1;
        if (chunk_q == CW'(NCHUNK - 1)) begin
          // Sign-extend both so the difference cannot wrap.
          pred_d   = ch_best_idx[LANES];
          run_d    = ch_sec_idx[LANES];
          max_d    = ch_best_sc[LANES];
          margin_d = {ch_best_sc[LANES][DATA_WIDTH-1], ch_best_sc[LANES]}
                   - {ch_sec_sc[LANES][DATA_WIDTH-1], ch_sec_sc[LANES]};
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    ready_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      chunk_q    <= '0;
      best_vld_q <= 1'b0;
      best_sc_q  <= '0;
      best_idx_q <= '0;
      sec_vld_q  <= 1'b0;
      sec_sc_q   <= '0;
      sec_idx_q  <= '0;
      pred_q     <= '0;
      run_q      <= '0;
      max_q      <= '0;
      margin_q   <= '0;
      in_ready_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      chunk_q    <= chunk_d;
      best_vld_q <= best_vld_d;
      best_sc_q  <= best_sc_d;
      best_idx_q <= best_idx_d;
      sec_vld_q  <= sec_vld_d;
      sec_sc_q   <= sec_sc_d;
      sec_idx_q  <= sec_idx_d;
      pred_q     <= pred_d;
      run_q      <= run_d;
      max_q      <= max_d;
      margin_q   <= margin_d;
      in_ready_q <= in_ready_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ready     = ready_q;
  assign predict   = {{(32-IW){1'b0}}, pred_q};
  assign runner_up = {{(32-IW){1'b0}}, run_q};
  assign max_score = max_q;
  assign margin    = margin_q;

endmodule

// File: doc/argmax_seq_top2.md
ARGMAX_SEQ_TOP2 -- requirements
Module: argmax_seq_top2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 30: signed two's-complement width of one class score.
REQ-002 SHALL have parameter NUM_CLASSES, default 10: class count; legal range 2..64.
REQ-003 SHALL have parameter LANES, default 2: scores compared per scan cycle; legal range 1..NUM_CLASSES.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port layer_out, input, DATA_WIDTH*NUM_CLASSES: packed scores; class k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port valid, input, 1: layer_out valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-009 SHALL have port ready, output, 1: result valid.
REQ-010 SHALL have port out_ack, input, 1: consumer takes the result.
REQ-011 SHALL have port predict, output, 32: winning class index, zero-extended.
REQ-012 SHALL have port runner_up, output, 32: second-best class index, zero-extended.
REQ-013 SHALL have port max_score, output, DATA_WIDTH: winning score.
REQ-014 SHALL have port margin, output, DATA_WIDTH+1: unsigned max_score minus second-best score.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL, in IDLE with valid=1, register layer_out, initialise best/second to the most negative value with index 0, clear the chunk counter, and go to SCAN.
REQ-018 SHALL, per SCAN cycle, fold classes [c*LANES, c*LANES+LANES-1] into running best/second, in ascending index order.
REQ-019 SHALL ignore lanes whose index is >= NUM_CLASSES in the final partial chunk.
REQ-020 SHALL use signed comparison; a candidate replaces best only if strictly greater. Ties go to the lower index for both best and second.
REQ-021 SHALL demote the displaced best to second when a candidate replaces best. Otherwise a candidate strictly greater than second replaces second.
REQ-022 SHALL leave SCAN after ceil(NUM_CLASSES/LANES) cycles and enter DONE.
REQ-023 SHALL assert ready in DONE with predict, runner_up, max_score and margin stable. Result latency is ceil(N/LANES)+1 cycles from the accept edge (6 cycles at defaults).
REQ-024 SHALL return to IDLE on the first DONE cycle with out_ack=1. ready drops the next cycle. Outputs hold their values until the next DONE.
REQ-025 SHALL ignore valid outside IDLE; the captured vector is unaffected by later layer_out changes.
REQ-026 SHALL compute margin at DATA_WIDTH+1 bits so max-positive minus max-negative does not overflow.
REQ-027 SHALL ignore out_ack outside DONE.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, go to IDLE, zero all score/index registers and predict/runner_up/max_score/margin, and drive ready=0 and in_ready=1 from the next cycle.
REQ-029 SHALL let rst during SCAN or DONE abort the operation, with no result produced; rst takes priority over valid and out_ack.

Structure
REQ-030 SHALL place the FSM state enum, the index-width function clog2(NUM_CLASSES) and the default parameters in package argmax_pkg.
REQ-031 SHALL implement the combinational one-candidate top-2 update as sub-module argmax_top2_cmp, instanced LANES times in a chain within one cycle.

Verification
REQ-032 SHALL cover defaults with scores 0..9 = {5,-3,12,7,12,0,-1,3,2,-20}: predict=2, runner_up=4, max_score=12, margin=0, ready on cycle 6 after accept.
REQ-033 SHALL cover all-negative scores {-9,-8,...,-1,-100}: predict=8, runner_up=7, margin=1.
REQ-034 SHALL cover DATA_WIDTH=30 with class0=2^29-1, class1=-2^29 and the rest equal to -2^29: predict=0, runner_up=1, margin=2^30-1.
REQ-035 SHALL cover LANES=3, NUM_CLASSES=10 with the max at class 9: predict=9, 4 scan cycles, lanes 10-11 ignored.
REQ-036 SHALL cover backpressure: out_ack held 0 for 5 cycles; ready and outputs remain stable, in_ready=0 throughout, and a valid pulse in this window is ignored.
REQ-037 SHALL cover rst asserted in the 3rd SCAN cycle: ready never rises, predict=0, in_ready=1 the cycle after; a following vector then completes normally.
